pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Parametrised ID/EX-class pipeline stage register for the CPU pipeline.
- Carries NUM_OPS operand words, a destination register index and a packed control bundle (ALU op, wmem, rmem, wreg, imm, wpc, jmp).
- Adds a valid/ready handshake, a 2-entry skid buffer for full throughput under back-pressure, and a synchronous flush for branch/jump squash.
- One instance sits between each pair of adjacent pipeline stages.

Parameters:
- DATA_W, 32, operand word width.
- NUM_OPS, 3, operand words per entry (R1..R3).
- REG_AW, 4, destination register index width.
- ALU_W, 3, ALU operation code width.
- CNT_W, 16, performance counter width (used only with the optional feature).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous squash of all held and incoming entries.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept an entry.
- in_ops  in  NUM_OPS*DATA_W  operand words; op k occupies bits [k*DATA_W +: DATA_W].
- in_dest  in  REG_AW  destination register index.
- in_ctrl  in  ex_ctrl_t  control bundle.
- out_valid  out  1  output entry present.
- out_ready  in  1  downstream accepts.
- out_ops  out  NUM_OPS*DATA_W  operand words.
- out_dest  out  REG_AW  destination register index.
- out_ctrl  out  ex_ctrl_t  control bundle.
- stall_cnt  out  CNT_W  back-pressure cycle count (only with PIPE_STAGE_PERF_EN).
- bubble_cnt  out  CNT_W  empty-output cycle count (only with PIPE_STAGE_PERF_EN).

Behaviour:
- Handshake fires:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Storage: main entry drives the out_* ports directly; the skid entry holds overflow.
- States: EMPTY, ONE, FULL.
  - out_valid = (state != EMPTY).
  - in_ready = (state != FULL); decoded from state only, with no combinational path from out_ready.
- Transitions when flush = 0:
  - EMPTY: in_fire -> ONE, main <= in.
  - ONE: in_fire & out_fire -> ONE, main <= in.
  - ONE: in_fire & !out_ready -> FULL, skid <= in.
  - ONE: !in_fire & out_fire -> EMPTY.
  - FULL: out_fire -> ONE, main <= skid. No input accepted.
- Timing: latency 1 cycle from in_fire to out_valid; sustained throughput 1 entry/cycle with out_ready held high.
- Held entries: out_* are stable while out_valid & !out_ready.
- Flush:
  - Overrides every transition; next state EMPTY.
  - The same-cycle in_fire and out_fire entries are discarded; upstream must not retry them.
  - Control fields of main and skid are cleared to 0 so no wreg/wmem/wpc/jmp leaks.
- Reset (rst = 0, asynchronous, at any time including mid-transfer):
  - state EMPTY; main and skid operands, dest and ctrl all 0.
  - out_valid = 0, in_ready = 1, counters 0.
- Reserved ALU codes: passed through unchanged; the stage never decodes ctrl.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- With the macro defined:
  - stall_cnt increments each cycle with out_valid & !out_ready.
  - bubble_cnt increments each cycle with out_valid = 0 after reset release.
  - Both saturate at all-ones, with no wrap.
  - flush does not clear the counters; only rst does.
- Without the macro: both ports remain and are tied to 0, and no counter registers are inferred.

Decomposition:
- Package pipe_pkg holds:
  - typedef ex_ctrl_t, a packed struct {alu_op[ALU_W-1:0], wmem, rmem, wreg, imm, wpc, jmp}.
  - EX_CTRL_NOP, an all-zero constant.
  - typedef stage_state_t {EMPTY, ONE, FULL}.
- Sub-module pipe_entry_reg: one entry register (ops, dest, ctrl) with load enable and synchronous control clear, instantiated for main and skid.

Test Plan:
- Reset release: rst low then high, no input -> out_valid = 0, in_ready = 1, out_ctrl = 0, out_ops = 0.
- Streaming:
  - Stimulus: 8 back-to-back entries, out_ready = 1, R1 = 0x1000+i, dest = i.
  - Required: each appears exactly 1 cycle after acceptance, in order, with no gaps and in_ready held at 1.
- Back-pressure:
  - Stimulus: accept A; drop out_ready for 3 cycles while offering B then C.
  - Required: B goes to skid, state FULL, in_ready = 0, and C is held off upstream.
  - Then raise out_ready: order A, B, C with no loss or duplication.
- Flush in FULL:
  - Stimulus: A in main, B in skid; assert flush with in_valid = 1 (entry D).
  - Required: next cycle out_valid = 0, wreg = wmem = jmp = 0, D never appears, in_ready = 1.
- Async reset mid-stall:
  - Stimulus: state FULL; rst low between clock edges.
  - Required: out_valid drops immediately with no clock edge, and after release behaviour matches a fresh reset.
- With PIPE_STAGE_PERF_EN:
  - 5 stalled cycles -> stall_cnt = 5.
  - Force 2^CNT_W+3 empty cycles -> bubble_cnt saturates at 0xFFFF (CNT_W = 16).

Source files
------------

// File: rtl/pipe_stage_skid_pkg.sv
// pipe_pkg: shared control bundle, NOP constant and skid-stage state encoding.
package pipe_pkg;
    localparam int EX_ALU_W = 3;
    typedef struct packed {
        logic [EX_ALU_W-1:0] alu_op;
        logic                wmem;
        logic                rmem;
        logic                wreg;
        logic                imm;
        logic                wpc;
        logic                jmp;
    } ex_ctrl_t;
    localparam ex_ctrl_t EX_CTRL_NOP = '0;
    typedef enum logic [1:0] {EMPTY, ONE, FULL} stage_state_t;
endpackage

// File: rtl/pipe_stage_skid_entry_reg.sv
// pipe_entry_reg: one pipeline entry (ops, dest, ctrl) with load enable and sync ctrl clear.
module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int NUM_OPS = 3,
    parameter int REG_AW  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ld,
    input  logic                      clr,
    input  logic [NUM_OPS*DATA_W-1:0] d_ops,
    input  logic [REG_AW-1:0]         d_dest,
    input  ex_ctrl_t                  d_ctrl,
    output logic [NUM_OPS*DATA_W-1:0] q_ops,
    output logic [REG_AW-1:0]         q_dest,
    output ex_ctrl_t                  q_ctrl
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_ops  <= '0;
            q_dest <= '0;
            q_ctrl <= EX_CTRL_NOP;
        end else begin
            if (ld) begin
                q_ops  <= d_ops;
                q_dest <= d_dest;
            end
            // clear wins over load so a squashed entry can never carry side effects
            q_ctrl <= clr ? EX_CTRL_NOP : ld ? d_ctrl : q_ctrl;
        end
    end
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: ID/EX-class stage register with valid/ready, 2-entry skid and flush.
// Optional PIPE_STAGE_PERF_EN adds saturating stall/bubble counters.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int NUM_OPS = 3,
    parameter int REG_AW  = 4,
    parameter int ALU_W   = 3,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_OPS*DATA_W-1:0] in_ops,
    input  logic [REG_AW-1:0]         in_dest,
    input  ex_ctrl_t                  in_ctrl,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_OPS*DATA_W-1:0] out_ops,
    output logic [REG_AW-1:0]         out_dest,
    output ex_ctrl_t                  out_ctrl,
    output logic [CNT_W-1:0]          stall_cnt,
    output logic [CNT_W-1:0]          bubble_cnt
);
    localparam int OW     = NUM_OPS * DATA_W;
    localparam int CTRL_W = ALU_W + 6;
    stage_state_t state, state_nx;
    logic in_fire, out_fire, main_ld, skid_ld;
    logic [OW-1:0] main_ops, skid_ops, main_d_ops;
    logic [REG_AW-1:0] main_dest, skid_dest, main_d_dest;
    ex_ctrl_t main_ctrl, skid_ctrl, main_d_ctrl;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= EMPTY;
        else      state <= state_nx;
    end
    always_comb begin
        state_nx = flush ? EMPTY :
                   state == EMPTY ? (in_fire ? ONE : EMPTY) :
                   state == ONE   ? (in_fire & !out_ready ? FULL : !in_fire & out_fire ? EMPTY : ONE) :
                                    (out_fire ? ONE : FULL);
    end
    // load enables are expressed from state and raw inputs to keep this block loop-free
    always_comb begin
        out_valid = state != EMPTY;
        in_ready  = state != FULL;
        main_ld   = !flush & (state == EMPTY ? in_valid :
                              state == ONE   ? in_valid & out_ready : out_ready);
        skid_ld   = !flush & (state == ONE) & in_valid & !out_ready;
    end
    always_comb begin
        main_d_ops  = state == FULL ? skid_ops  : in_ops;
        main_d_dest = state == FULL ? skid_dest : in_dest;
        main_d_ctrl = state == FULL ? skid_ctrl : in_ctrl;
    end
    pipe_entry_reg #(.DATA_W(DATA_W), .NUM_OPS(NUM_OPS), .REG_AW(REG_AW)) u_main (
        .clk(clk), .rst(rst), .ld(main_ld), .clr(flush),
        .d_ops(main_d_ops), .d_dest(main_d_dest), .d_ctrl(main_d_ctrl),
        .q_ops(main_ops), .q_dest(main_dest), .q_ctrl(main_ctrl)
    );
    pipe_entry_reg #(.DATA_W(DATA_W), .NUM_OPS(NUM_OPS), .REG_AW(REG_AW)) u_skid (
        .clk(clk), .rst(rst), .ld(skid_ld), .clr(flush),
        .d_ops(in_ops), .d_dest(in_dest), .d_ctrl(in_ctrl),
        .q_ops(skid_ops), .q_dest(skid_dest), .q_ctrl(skid_ctrl)
    );
    assign out_ops  = main_ops;
    assign out_dest = main_dest;
    assign out_ctrl = ex_ctrl_t'(CTRL_W'(main_ctrl));
`ifdef PIPE_STAGE_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid & !out_ready & ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
            if (!out_valid & ~&bubble_cnt) bubble_cnt <= bubble_cnt + 1'b1;
        end
    end
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed + random stimulus against a 2-deep queue reference model.
module tb_pipe_stage_skid;
    import pipe_pkg::*;
    localparam int DW = 32, NO = 3, RA = 4, CW = 16, OW = DW * NO;
    localparam int CMAX = (1 << CW) - 1;
    typedef struct packed {
        logic [OW-1:0] ops;
        logic [RA-1:0] dest;
        ex_ctrl_t      ctrl;
    } ent_t;
    logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
    logic in_ready, out_valid;
    logic [OW-1:0] in_ops = '0, out_ops;
    logic [RA-1:0] in_dest = '0, out_dest;
    ex_ctrl_t in_ctrl = '0, out_ctrl;
    logic [CW-1:0] stall_cnt, bubble_cnt;
    always #5 clk = ~clk;
    pipe_stage_skid dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ops(in_ops), .in_dest(in_dest), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ops(out_ops), .out_dest(out_dest), .out_ctrl(out_ctrl),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );
    ent_t q[$];
    ex_ctrl_t idle_ctrl;
    int unsigned stall_m = 0, bubble_m = 0;
    int pass_n = 0, total_n = 0;
    task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
        total_n++;
        assert (o === e) pass_n++;
        else $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    endtask
    function automatic ent_t rnd();
        return ent_t'({$urandom, $urandom, $urandom, 4'($urandom), 9'($urandom)});
    endfunction
    task automatic chk_cnt();
`ifdef PIPE_STAGE_PERF_EN
        chk("stall_cnt", stall_cnt, stall_m);
        chk("bubble_cnt", bubble_cnt, bubble_m);
`else
        chk("stall_cnt_tied", stall_cnt, 0);
        chk("bubble_cnt_tied", bubble_cnt, 0);
`endif
    endtask
    // one clock: drive at posedge+1, check at posedge+2, advance model at next posedge
    task automatic cycle(input logic v, input logic r, input logic fl, input ent_t e);
        bit mi, mo;
        in_valid = v; out_ready = r; flush = fl;
        {in_ops, in_dest, in_ctrl} = e;
        #1;
        chk("out_valid", out_valid, q.size() > 0);
        chk("in_ready", in_ready, q.size() < 2);
        if (q.size() > 0) begin
            chk("out_ops", out_ops, q[0].ops);
            chk("out_dest", out_dest, q[0].dest);
            chk("out_ctrl", out_ctrl, q[0].ctrl);
        end else chk("idle_ctrl", out_ctrl, idle_ctrl);
        chk_cnt();
        mi = v && q.size() < 2;
        mo = r && q.size() > 0;
        if (q.size() > 0 && !r && stall_m < CMAX) stall_m++;
        if (q.size() == 0 && bubble_m < CMAX) bubble_m++;
        @(posedge clk); #1;
        if (fl) begin
            q.delete();
            idle_ctrl = '0;
        end else begin
            if (mo) begin
                idle_ctrl = q[0].ctrl;
                void'(q.pop_front());
            end
            if (mi) q.push_back(e);
        end
    endtask
    // asynchronous reset asserted between edges, released between edges
    task automatic do_reset();
        #2 rst = 0;
        in_valid = 0; out_ready = 0; flush = 0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_ctrl", out_ctrl, 0);
        chk("rst_out_ops", out_ops, 0);
        chk("rst_out_dest", out_dest, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_bubble", bubble_cnt, 0);
        q.delete();
        idle_ctrl = '0; stall_m = 0; bubble_m = 0;
        @(posedge clk);
        #3 rst = 1;
        @(posedge clk); #1;
        bubble_m = 1;
    endtask
    initial begin
        ent_t a, b, c, d;
        #1 rst = 0;
        #1;
        chk("init_out_valid", out_valid, 0);
        chk("init_in_ready", in_ready, 1);
        chk("init_out_ctrl", out_ctrl, 0);
        chk("init_out_ops", out_ops, 0);
        idle_ctrl = '0;
        @(posedge clk);
        #3 rst = 1;
        @(posedge clk); #1;
        bubble_m = 1;
        cycle(0, 0, 0, rnd());
        cycle(0, 1, 0, rnd());
        // streaming: 8 back-to-back entries
        for (int i = 0; i < 8; i++) begin
            a = rnd();
            a.ops[DW-1:0] = 32'h1000 + i;
            a.dest = RA'(i);
            cycle(1, 1, 0, a);
            if (i > 0) chk("stream_dest", out_dest, RA'(i));
        end
        cycle(0, 1, 0, rnd());
        cycle(0, 1, 0, rnd());
        // back-pressure: A accepted, then B to skid, C held off
        a = rnd(); b = rnd(); c = rnd();
        cycle(1, 1, 0, a);
        cycle(1, 0, 0, b);
        cycle(1, 0, 0, c);
        chk("bp_full_ready", in_ready, 0);
        cycle(1, 0, 0, c);
        chk("bp_hold_dest", out_dest, a.dest);
        cycle(1, 1, 0, c);
        chk("bp_b_next", out_ops, b.ops);
        cycle(1, 1, 0, c);
        chk("bp_c_next", out_ops, c.ops);
        cycle(0, 1, 0, rnd());
        cycle(0, 1, 0, rnd());
        // flush while FULL with D offered
        a = rnd(); b = rnd(); d = rnd();
        d.ctrl.wreg = 1; d.ctrl.wmem = 1; d.ctrl.jmp = 1; d.ctrl.wpc = 1;
        b.ctrl.wreg = 1; b.ctrl.jmp = 1;
        cycle(1, 0, 0, a);
        cycle(1, 0, 0, b);
        cycle(1, 0, 1, d);
        chk("flush_valid", out_valid, 0);
        chk("flush_wreg", out_ctrl.wreg, 0);
        chk("flush_wmem", out_ctrl.wmem, 0);
        chk("flush_jmp", out_ctrl.jmp, 0);
        chk("flush_ready", in_ready, 1);
        cycle(0, 1, 0, rnd());
        cycle(0, 1, 0, rnd());
        // flush in ONE with simultaneous in_fire and out_fire
        a = rnd(); d = rnd(); d.ctrl.wreg = 1;
        cycle(1, 1, 0, a);
        cycle(1, 1, 1, d);
        cycle(0, 1, 0, rnd());
        // async reset mid-stall
        cycle(1, 0, 0, rnd());
        cycle(1, 0, 0, rnd());
        chk("pre_rst_full", in_ready, 0);
        do_reset();
        cycle(0, 0, 0, rnd());
        cycle(1, 1, 0, rnd());
        cycle(1, 1, 0, rnd());
        cycle(0, 1, 0, rnd());
        // randomized traffic against the queue model
        repeat (400) cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                           $urandom_range(0, 24) == 0, rnd());
        repeat (3) cycle(0, 1, 0, rnd());
`ifdef PIPE_STAGE_PERF_EN
        do_reset();
        cycle(1, 0, 0, rnd());
        repeat (5) cycle(0, 0, 0, rnd());
        chk("stall_5", stall_cnt, 5);
        cycle(0, 1, 0, rnd());
        repeat ((1 << CW) + 3) cycle(0, 1, 0, rnd());
        chk("bubble_sat", bubble_cnt, 16'hFFFF);
        flush = 1;
        @(posedge clk); #1;
        flush = 0;
        chk("flush_keeps_cnt", bubble_cnt, 16'hFFFF);
`endif
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
